// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizing and reset image for the parametrised register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 4;

    function automatic logic [DEF_DATA_W-1:0] def_reset_val(input int i);
        return (i == 0) ? 8'h04 : (i == 1) ? 8'h03 : 8'h00;
    endfunction

    localparam logic [2*DEF_DATA_W-1:0] DEF_RESET_IMAGE = {def_reset_val(1), def_reset_val(0)};

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port with write bypass and pending status capture.
module regfile_rd_port #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                rd_addr_i,
    input  logic                             wr_en_i,
    input  logic [ADDR_W-1:0]                wr_addr_i,
    input  logic [DATA_W-1:0]                wr_data_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  mem_i,
    input  logic [NUM_REGS-1:0]              pending_i,
    output logic [DATA_W-1:0]                rd_data_o,
    output logic                             busy_o
);

    logic              in_range;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              busy_q, busy_d;

    assign in_range = {1'b0, rd_addr_i} < (ADDR_W+1)'(NUM_REGS);

    // pending_i is the post-edge vector, so a same-cycle write/reserve is already reflected
    always_comb begin
        rd_data_d = !in_range ? '0 : (wr_en_i && rd_addr_i == wr_addr_i) ? wr_data_i : mem_i[rd_addr_i];
        busy_d    = in_range && pending_i[rd_addr_i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/regfile_param.sv
// regfile_param: NUM_REGS x DATA_W register file, two bypassed read ports, one write port,
// and a per-register pending bit set by reservations and cleared by writeback.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = (NUM_REGS*DATA_W)'(DEF_RESET_IMAGE),
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                busy1,
    output logic                busy2,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [NUM_REGS-1:0]             pending_q, pending_d;
    logic                            wr_ok, rsv_ok;

    assign wr_ok  = wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(NUM_REGS));
    assign rsv_ok = rsv_en && ({1'b0, rsv_addr} < (ADDR_W+1)'(NUM_REGS));

    // reserve applied after write so a new producer wins over a same-cycle writeback
    always_comb begin
        mem_d     = mem_q;
        pending_d = pending_q;
        if (wr_ok) begin
            mem_d[wr_addr]     = wr_data;
            pending_d[wr_addr] = 1'b0;
        end
        if (rsv_ok)
            pending_d[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q     <= RESET_VALS;
            pending_q <= '0;
        end else begin
            mem_q     <= mem_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    regfile_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rd1 (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i (rd_addr1),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .mem_i     (mem_q),
        .pending_i (pending_d),
        .rd_data_o (rd_data1),
        .busy_o    (busy1)
    );

    regfile_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rd2 (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i (rd_addr2),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .mem_i     (mem_q),
        .pending_i (pending_d),
        .rd_data_o (rd_data2),
        .busy_o    (busy2)
    );

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed scoreboard bench for a 4-entry and a 3-entry instance sharing stimulus.
module tb_regfile_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, rsv_addr = '0;
    logic       wr_en = 1'b0, rsv_en = 1'b0;
    logic [7:0] wr_data = '0;

    logic [7:0] d4_1, d4_2, d3_1, d3_2;
    logic       b4_1, b4_2, b3_1, b3_2;
    logic [3:0] p4;
    logic [2:0] p3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d1, d2, e1, e2;
        logic       b1, b2, c1, c2;
        logic [3:0] p;
        logic [2:0] q;
    } exp_t;

    exp_t sb[$];

    logic [7:0] mem4 [0:3];
    logic [7:0] mem3 [0:3];
    logic [3:0] pend4;
    logic [2:0] pend3;

    always #5 clk = ~clk;

    regfile_param dut4 (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_data1(d4_1), .rd_data2(d4_2), .busy1(b4_1), .busy2(b4_2), .pending(p4)
    );

    regfile_param #(.NUM_REGS(3)) dut3 (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_data1(d3_1), .rd_data2(d3_2), .busy1(b3_1), .busy2(b3_2), .pending(p3)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mem4[0] = 8'h04; mem4[1] = 8'h03; mem4[2] = 8'h00; mem4[3] = 8'h00;
        mem3[0] = 8'h04; mem3[1] = 8'h03; mem3[2] = 8'h00; mem3[3] = 8'h00;
        pend4 = '0;
        pend3 = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " d4_1"}, d4_1, 8'h00);
        chk({tag, " d4_2"}, d4_2, 8'h00);
        chk({tag, " b4"}, {6'b0, b4_2, b4_1}, 8'h00);
        chk({tag, " p4"}, {4'b0, p4}, 8'h00);
        chk({tag, " d3_1"}, d3_1, 8'h00);
        chk({tag, " d3_2"}, d3_2, 8'h00);
        chk({tag, " b3"}, {6'b0, b3_2, b3_1}, 8'h00);
        chk({tag, " p3"}, {5'b0, p3}, 8'h00);
    endtask

    // drive one cycle, predict post-edge outputs for both instances, then compare after the edge
    task automatic step(input string tag, input logic [1:0] a1, input logic [1:0] a2,
                        input logic we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic re, input logic [1:0] ra);
        exp_t e, o;
        rd_addr1 = a1; rd_addr2 = a2;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        e.d1 = (we && a1 == wa) ? wd : mem4[a1];
        e.d2 = (we && a2 == wa) ? wd : mem4[a2];
        if (we) begin mem4[wa] = wd; pend4[wa] = 1'b0; end
        if (re) pend4[ra] = 1'b1;
        e.b1 = pend4[a1];
        e.b2 = pend4[a2];
        e.p  = pend4;
        e.e1 = (a1 > 2'd2) ? 8'h00 : (we && a1 == wa) ? wd : mem3[a1];
        e.e2 = (a2 > 2'd2) ? 8'h00 : (we && a2 == wa) ? wd : mem3[a2];
        if (we && wa < 2'd3) begin mem3[wa] = wd; pend3[wa] = 1'b0; end
        if (re && ra < 2'd3) pend3[ra] = 1'b1;
        e.c1 = (a1 < 2'd3) ? pend3[a1] : 1'b0;
        e.c2 = (a2 < 2'd3) ? pend3[a2] : 1'b0;
        e.q  = pend3;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk({tag, " d4_1"}, d4_1, o.d1);
        chk({tag, " d4_2"}, d4_2, o.d2);
        chk({tag, " b4"}, {6'b0, b4_2, b4_1}, {6'b0, o.b2, o.b1});
        chk({tag, " p4"}, {4'b0, p4}, {4'b0, o.p});
        chk({tag, " d3_1"}, d3_1, o.e1);
        chk({tag, " d3_2"}, d3_2, o.e2);
        chk({tag, " b3"}, {6'b0, b3_2, b3_1}, {6'b0, o.c2, o.c1});
        chk({tag, " p3"}, {5'b0, p3}, {5'b0, o.q});
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #2 check_reset_outputs("rst_async");
        @(posedge clk);
        #1 check_reset_outputs("rst_held");
        rst = 1'b1;

        step("reset_img",   2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        step("wr_r2",       2'd0, 2'd1, 1'b1, 2'd2, 8'hA5, 1'b0, 2'd0);
        step("rd_r2",       2'd2, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        step("bypass_r1",   2'd1, 2'd1, 1'b1, 2'd1, 8'h7E, 1'b0, 2'd0);
        step("rd_r1",       2'd1, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        step("rsv_r3",      2'd3, 2'd3, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
        step("busy_r3",     2'd3, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        step("wb_r3",       2'd3, 2'd3, 1'b1, 2'd3, 8'h11, 1'b0, 2'd0);
        step("rsv_wr_r3",   2'd3, 2'd0, 1'b1, 2'd3, 8'h22, 1'b1, 2'd3);
        step("rd_r3",       2'd3, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        step("oor_wr",      2'd3, 2'd2, 1'b1, 2'd3, 8'hFF, 1'b0, 2'd0);
        step("oor_chk01",   2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        step("oor_chk23",   2'd2, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        step("rsv_r2",      2'd2, 2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
        step("rsv_wr_p2",   2'd1, 2'd2, 1'b1, 2'd1, 8'h5A, 1'b1, 2'd2);
        step("rsv_r0",      2'd0, 2'd2, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        step("wr_r0",       2'd2, 2'd0, 1'b1, 2'd0, 8'h55, 1'b1, 2'd1);

        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_mid");
        model_reset();
        #3 rst = 1'b1;
        step("post_rst",    2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        step("post_rst2",   2'd2, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
